// File: rtl/axis_width_converter.sv
// axis_width_converter: AXI-Stream upsize/downsize/pass-through converter with tkeep/tlast and optional output skid buffer
// Ports: aclk, areset (async, active-high); in_tdata/in_tkeep/in_tlast/in_tvalid/in_tready: IN_W-bit slave stream;
//        out_tdata/out_tkeep/out_tlast/out_tvalid/out_tready: OUT_W-bit master stream; OUT_REG=1 adds a skid entry
//        so in_tready never depends combinationally on out_tready.
module axis_width_converter #(
    parameter int IN_W    = 256,
    parameter int OUT_W   = 512,
    parameter bit OUT_REG = 1'b1
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [IN_W-1:0]    in_tdata,
    input  logic [IN_W/8-1:0]  in_tkeep,
    input  logic               in_tlast,
    input  logic               in_tvalid,
    output logic               in_tready,
    output logic [OUT_W-1:0]   out_tdata,
    output logic [OUT_W/8-1:0] out_tkeep,
    output logic               out_tlast,
    output logic               out_tvalid,
    input  logic               out_tready
);
    localparam int MIN_W = IN_W < OUT_W ? IN_W : OUT_W;
    localparam int MAX_W = IN_W < OUT_W ? OUT_W : IN_W;
    localparam int R     = MAX_W / MIN_W;
    localparam int CW    = R > 1 ? $clog2(R) : 1;
    localparam int KI    = IN_W / 8;
    localparam int KO    = OUT_W / 8;
    logic             en;
    logic             c_valid, c_ready, c_last;
    logic [OUT_W-1:0] c_data;
    logic [KO-1:0]    c_keep;
    logic             s_valid, s_last;
    logic [OUT_W-1:0] s_data;
    logic [KO-1:0]    s_keep;
    logic             o_free;
    if (IN_W % 8 != 0 || OUT_W % 8 != 0 || MAX_W % MIN_W != 0) begin : g_bad
        $fatal(1, "axis_width_converter: widths must be byte multiples with an integer ratio");
    end
    if (OUT_W > IN_W) begin : g_up
        logic [CW-1:0]    cnt;
        logic [OUT_W-1:0] acc_d;
        logic [KO-1:0]    acc_k;
        logic             fin;
        assign fin       = in_tlast || cnt == CW'(R - 1);
        assign c_valid   = in_tvalid && en && fin;
        assign c_data    = acc_d | (OUT_W'(in_tdata) << (cnt * IN_W));
        assign c_keep    = acc_k | (KO'(in_tkeep) << (cnt * KI));
        assign c_last    = in_tlast;
        assign in_tready = en && c_ready;
        always_ff @(posedge aclk or posedge areset)
            if (areset) begin
                cnt   <= '0;
                acc_d <= '0;
                acc_k <= '0;
            end else if (in_tvalid && in_tready) begin
                cnt   <= fin ? '0 : cnt + 1'b1;
                acc_d <= fin ? '0 : c_data;
                acc_k <= fin ? '0 : c_keep;
            end
    end else if (IN_W > OUT_W) begin : g_dn
        // slice 0 bypasses straight to the output stage; w_* holds the remaining slices
        logic             w_valid, w_last;
        logic [CW-1:0]    cnt, lst, hi, in_lst;
        logic [IN_W-1:0]  w_d;
        logic [KI-1:0]    w_k;
        always_comb begin
            hi = '0;
            for (int i = 0; i < R; i++) hi = |in_tkeep[i*KO +: KO] ? CW'(i) : hi;
        end
        assign in_lst    = in_tlast ? hi : CW'(R - 1);
        assign c_valid   = w_valid || (in_tvalid && en);
        assign c_data    = w_valid ? w_d[cnt*OUT_W +: OUT_W] : in_tdata[OUT_W-1:0];
        assign c_keep    = w_valid ? w_k[cnt*KO +: KO] : in_tkeep[KO-1:0];
        assign c_last    = w_valid ? (w_last && cnt == lst) : (in_tlast && in_lst == '0);
        assign in_tready = en && !w_valid && c_ready;
        always_ff @(posedge aclk or posedge areset)
            if (areset) begin
                w_valid <= 1'b0;
                w_last  <= 1'b0;
                cnt     <= '0;
                lst     <= '0;
                w_d     <= '0;
                w_k     <= '0;
            end else if (in_tvalid && in_tready) begin
                w_valid <= in_lst != '0;
                w_last  <= in_tlast;
                cnt     <= CW'(1);
                lst     <= in_lst;
                w_d     <= in_tdata;
                w_k     <= in_tkeep;
            end else if (w_valid && c_ready) begin
                w_valid <= cnt != lst;
                cnt     <= cnt + 1'b1;
            end
    end else begin : g_eq
        assign c_valid   = in_tvalid && en;
        assign c_data    = in_tdata;
        assign c_keep    = in_tkeep;
        assign c_last    = in_tlast;
        assign in_tready = en && c_ready;
    end
    assign o_free  = !out_tvalid || out_tready;
    assign c_ready = OUT_REG ? !s_valid : o_free;
    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            en         <= 1'b0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tkeep  <= '0;
            out_tlast  <= 1'b0;
            s_valid    <= 1'b0;
            s_data     <= '0;
            s_keep     <= '0;
            s_last     <= 1'b0;
        end else begin
            en <= 1'b1;
            if (o_free) begin
                out_tvalid <= s_valid || (c_valid && c_ready);
                s_valid    <= 1'b0;
                if (s_valid) {out_tdata, out_tkeep, out_tlast} <= {s_data, s_keep, s_last};
                else if (c_valid && c_ready) {out_tdata, out_tkeep, out_tlast} <= {c_data, c_keep, c_last};
            end else if (c_valid && c_ready) begin
                s_valid                  <= 1'b1;
                {s_data, s_keep, s_last} <= {c_data, c_keep, c_last};
            end
        end
endmodule

// File: tb/tb_axis_width_converter.sv
// tb_axis_width_converter: directed and randomized checks of axis_width_converter in four configurations
module tb_axis_width_converter;
    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;
    int nvec = 0;
    int nerr = 0;
    // a: 256->512 skid, b: 64->256 no skid, d: 512->256 no skid, e: 256->256 skid
    logic [255:0] a_in_tdata;  logic [31:0] a_in_tkeep;  logic a_in_tlast, a_in_tvalid, a_in_tready;
    logic [511:0] a_out_tdata; logic [63:0] a_out_tkeep; logic a_out_tlast, a_out_tvalid, a_out_tready;
    logic [63:0]  b_in_tdata;  logic [7:0]  b_in_tkeep;  logic b_in_tlast, b_in_tvalid, b_in_tready;
    logic [255:0] b_out_tdata; logic [31:0] b_out_tkeep; logic b_out_tlast, b_out_tvalid, b_out_tready;
    logic [511:0] d_in_tdata;  logic [63:0] d_in_tkeep;  logic d_in_tlast, d_in_tvalid, d_in_tready;
    logic [255:0] d_out_tdata; logic [31:0] d_out_tkeep; logic d_out_tlast, d_out_tvalid, d_out_tready;
    logic [255:0] e_in_tdata;  logic [31:0] e_in_tkeep;  logic e_in_tlast, e_in_tvalid, e_in_tready;
    logic [255:0] e_out_tdata; logic [31:0] e_out_tkeep; logic e_out_tlast, e_out_tvalid, e_out_tready;
    localparam int N = 1000;
    logic [255:0] eq_d [N];
    logic [31:0]  eq_k [N];
    logic         eq_l [N];

    axis_width_converter #(.IN_W(256), .OUT_W(512), .OUT_REG(1'b1)) u_a (
        .aclk(aclk), .areset(areset),
        .in_tdata(a_in_tdata), .in_tkeep(a_in_tkeep), .in_tlast(a_in_tlast), .in_tvalid(a_in_tvalid), .in_tready(a_in_tready),
        .out_tdata(a_out_tdata), .out_tkeep(a_out_tkeep), .out_tlast(a_out_tlast), .out_tvalid(a_out_tvalid), .out_tready(a_out_tready));
    axis_width_converter #(.IN_W(64), .OUT_W(256), .OUT_REG(1'b0)) u_b (
        .aclk(aclk), .areset(areset),
        .in_tdata(b_in_tdata), .in_tkeep(b_in_tkeep), .in_tlast(b_in_tlast), .in_tvalid(b_in_tvalid), .in_tready(b_in_tready),
        .out_tdata(b_out_tdata), .out_tkeep(b_out_tkeep), .out_tlast(b_out_tlast), .out_tvalid(b_out_tvalid), .out_tready(b_out_tready));
    axis_width_converter #(.IN_W(512), .OUT_W(256), .OUT_REG(1'b0)) u_d (
        .aclk(aclk), .areset(areset),
        .in_tdata(d_in_tdata), .in_tkeep(d_in_tkeep), .in_tlast(d_in_tlast), .in_tvalid(d_in_tvalid), .in_tready(d_in_tready),
        .out_tdata(d_out_tdata), .out_tkeep(d_out_tkeep), .out_tlast(d_out_tlast), .out_tvalid(d_out_tvalid), .out_tready(d_out_tready));
    axis_width_converter #(.IN_W(256), .OUT_W(256), .OUT_REG(1'b1)) u_e (
        .aclk(aclk), .areset(areset),
        .in_tdata(e_in_tdata), .in_tkeep(e_in_tkeep), .in_tlast(e_in_tlast), .in_tvalid(e_in_tvalid), .in_tready(e_in_tready),
        .out_tdata(e_out_tdata), .out_tkeep(e_out_tkeep), .out_tlast(e_out_tlast), .out_tvalid(e_out_tvalid), .out_tready(e_out_tready));

    task automatic test_reset;
        repeat (2) @(posedge aclk);
        #1;
        nvec++; if (a_out_tvalid !== 1'b0) begin nerr++; $display("FAIL rst_out_tvalid: got %b want 0", a_out_tvalid); end
        nvec++; if (a_out_tdata !== '0 || a_out_tkeep !== '0 || a_out_tlast !== 1'b0) begin nerr++; $display("FAIL rst_out_fields: got %h/%h/%b want zeros", a_out_tdata, a_out_tkeep, a_out_tlast); end
        nvec++; if ({a_in_tready, b_in_tready, d_in_tready, e_in_tready} !== 4'b0000) begin nerr++; $display("FAIL rst_in_tready: got %b want 0000", {a_in_tready, b_in_tready, d_in_tready, e_in_tready}); end
        areset = 1'b0;
        #1;
        nvec++; if (a_in_tready !== 1'b0) begin nerr++; $display("FAIL rel_ready_early: got %b want 0", a_in_tready); end
        @(posedge aclk); #1;
        nvec++; if ({a_in_tready, b_in_tready, d_in_tready, e_in_tready} !== 4'b1111) begin nerr++; $display("FAIL rel_ready_rise: got %b want 1111", {a_in_tready, b_in_tready, d_in_tready, e_in_tready}); end
    endtask

    task automatic test_upsize;
        logic [255:0] w [4];
        for (int i = 0; i < 4; i++) w[i] = {8{32'hA000_0000 | 32'(i)}};
        a_out_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_tdata = w[i]; a_in_tkeep = '1; a_in_tlast = i[0]; a_in_tvalid = 1'b1;
            nvec++; if (a_in_tready !== 1'b1) begin nerr++; $display("FAIL up_in_tready beat %0d: got %b want 1", i, a_in_tready); end
            @(posedge aclk); #1;
            if (i[0]) begin
                nvec++; if (a_out_tvalid !== 1'b1 || a_out_tdata !== {w[i], w[i-1]} || a_out_tkeep !== '1 || a_out_tlast !== 1'b1)
                    begin nerr++; $display("FAIL up_word %0d: got v=%b l=%b d=%h want v=1 l=1 d=%h", i, a_out_tvalid, a_out_tlast, a_out_tdata, {w[i], w[i-1]}); end
            end else begin
                nvec++; if (a_out_tvalid !== 1'b0) begin nerr++; $display("FAIL up_idle %0d: got %b want 0", i, a_out_tvalid); end
            end
        end
        a_in_tvalid = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic test_upsize_partial;
        logic [63:0] c [3];
        for (int i = 0; i < 3; i++) c[i] = {2{32'hC000_0000 | 32'(i)}};
        b_out_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_in_tdata = c[i]; b_in_tkeep = '1; b_in_tlast = (i == 2); b_in_tvalid = 1'b1;
            nvec++; if (b_in_tready !== 1'b1) begin nerr++; $display("FAIL part_in_tready %0d: got %b want 1", i, b_in_tready); end
            @(posedge aclk); #1;
        end
        b_in_tvalid = 1'b0;
        nvec++; if (b_out_tvalid !== 1'b1 || b_out_tlast !== 1'b1) begin nerr++; $display("FAIL part_valid_last: got %b%b want 11", b_out_tvalid, b_out_tlast); end
        nvec++; if (b_out_tdata !== {64'h0, c[2], c[1], c[0]}) begin nerr++; $display("FAIL part_data: got %h want %h", b_out_tdata, {64'h0, c[2], c[1], c[0]}); end
        nvec++; if (b_out_tkeep !== 32'h00FF_FFFF) begin nerr++; $display("FAIL part_keep: got %h want 00ffffff", b_out_tkeep); end
        @(posedge aclk); #1;
    endtask

    task automatic test_downsize;
        logic [255:0] d0, d1, e0, e1;
        d0 = {8{32'hD000_0000}}; d1 = {8{32'hD000_0001}};
        e0 = {8{32'hE000_0000}}; e1 = {8{32'hE000_0001}};
        d_out_tready = 1'b1;
        d_in_tdata = {d1, d0}; d_in_tkeep = '1; d_in_tlast = 1'b0; d_in_tvalid = 1'b1;
        nvec++; if (d_in_tready !== 1'b1) begin nerr++; $display("FAIL dn_ready0: got %b want 1", d_in_tready); end
        @(posedge aclk); #1;
        d_in_tdata = {e1, e0}; d_in_tkeep = 64'h0000_0000_FFFF_FFFF; d_in_tlast = 1'b1;
        nvec++; if ({d_out_tvalid, d_out_tlast} !== 2'b10 || d_out_tdata !== d0 || d_out_tkeep !== '1) begin nerr++; $display("FAIL dn_D0: got v/l=%b%b d=%h want 10 %h", d_out_tvalid, d_out_tlast, d_out_tdata, d0); end
        nvec++; if (d_in_tready !== 1'b0) begin nerr++; $display("FAIL dn_hold: got %b want 0", d_in_tready); end
        @(posedge aclk); #1;
        nvec++; if ({d_out_tvalid, d_out_tlast} !== 2'b10 || d_out_tdata !== d1) begin nerr++; $display("FAIL dn_D1: got v/l=%b%b d=%h want 10 %h", d_out_tvalid, d_out_tlast, d_out_tdata, d1); end
        nvec++; if (d_in_tready !== 1'b1) begin nerr++; $display("FAIL dn_ready1: got %b want 1", d_in_tready); end
        @(posedge aclk); #1;
        d_in_tvalid = 1'b0;
        nvec++; if ({d_out_tvalid, d_out_tlast} !== 2'b11 || d_out_tdata !== e0 || d_out_tkeep !== '1) begin nerr++; $display("FAIL dn_E0: got v/l=%b%b d=%h k=%h want 11 %h", d_out_tvalid, d_out_tlast, d_out_tdata, d_out_tkeep, e0); end
        @(posedge aclk); #1;
        nvec++; if (d_out_tvalid !== 1'b0) begin nerr++; $display("FAIL dn_skip_E1: got %b want 0", d_out_tvalid); end
    endtask

    task automatic test_backpressure;
        int got;
        bit ok, stall;
        logic [511:0] prev;
        logic [3:0] pat;
        got = 0; stall = 1'b0; prev = '0; pat = 4'b1001;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a_in_tdata = 256'(i); a_in_tkeep = '1; a_in_tlast = 1'b0; a_in_tvalid = 1'b1;
                    ok = 1'b0;
                    for (int t = 0; t < 100 && !ok; t++) begin
                        #2; ok = a_in_tready;
                        @(posedge aclk); #1;
                    end
                end
                a_in_tvalid = 1'b0;
            end
            begin
                for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
                    a_out_tready = pat[cyc % 4];
                    #2;
                    if (stall) begin
                        nvec++; if (a_out_tvalid !== 1'b1 || a_out_tdata !== prev) begin nerr++; $display("FAIL bp_stable: got v=%b d=%h want 1 %h", a_out_tvalid, a_out_tdata, prev); end
                    end
                    if (a_out_tvalid && a_out_tready) begin
                        nvec++; if (a_out_tdata !== {256'(2*got+1), 256'(2*got)}) begin nerr++; $display("FAIL bp_word %0d: got %h want %h", got, a_out_tdata, {256'(2*got+1), 256'(2*got)}); end
                        got++;
                    end
                    stall = a_out_tvalid && !a_out_tready;
                    prev = a_out_tdata;
                    @(posedge aclk); #1;
                end
            end
        join
        nvec++; if (got != 4) begin nerr++; $display("FAIL bp_count: got %0d words want 4", got); end
        a_out_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        nvec++; if (a_out_tvalid !== 1'b0) begin nerr++; $display("FAIL bp_extra: got %b want 0", a_out_tvalid); end
    endtask

    task automatic test_reset_mid;
        logic [255:0] f0, f1;
        f0 = {8{32'hF000_0000}}; f1 = {8{32'hF000_0001}};
        a_out_tready = 1'b0; a_in_tkeep = '1; a_in_tlast = 1'b0; a_in_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_tdata = {8{32'h6000_0000 | 32'(i)}};
            @(posedge aclk); #1;
        end
        a_in_tvalid = 1'b0;
        nvec++; if (a_out_tvalid !== 1'b1) begin nerr++; $display("FAIL rm_pre_valid: got %b want 1", a_out_tvalid); end
        areset = 1'b1;
        #1;
        nvec++; if (a_out_tvalid !== 1'b0 || a_in_tready !== 1'b0) begin nerr++; $display("FAIL rm_assert: got v=%b r=%b want 0 0", a_out_tvalid, a_in_tready); end
        @(posedge aclk); #1;
        areset = 1'b0;
        #1;
        nvec++; if (a_in_tready !== 1'b0) begin nerr++; $display("FAIL rm_ready_early: got %b want 0", a_in_tready); end
        @(posedge aclk); #1;
        nvec++; if (a_in_tready !== 1'b1) begin nerr++; $display("FAIL rm_ready_rise: got %b want 1", a_in_tready); end
        a_out_tready = 1'b1;
        a_in_tdata = f0; a_in_tvalid = 1'b1;
        @(posedge aclk); #1;
        nvec++; if (a_out_tvalid !== 1'b0) begin nerr++; $display("FAIL rm_stale: got %b d=%h want 0", a_out_tvalid, a_out_tdata); end
        a_in_tdata = f1; a_in_tlast = 1'b1;
        @(posedge aclk); #1;
        a_in_tvalid = 1'b0;
        nvec++; if (a_out_tvalid !== 1'b1 || a_out_tdata !== {f1, f0} || a_out_tlast !== 1'b1) begin nerr++; $display("FAIL rm_first: got v=%b l=%b d=%h want 1 1 %h", a_out_tvalid, a_out_tlast, a_out_tdata, {f1, f0}); end
        @(posedge aclk); #1;
    endtask

    task automatic test_equal;
        int i, j;
        for (int n = 0; n < N; n++) begin
            for (int k = 0; k < 8; k++) eq_d[n][k*32 +: 32] = $urandom;
            eq_k[n] = $urandom;
            eq_l[n] = 1'($urandom_range(0, 1));
        end
        i = 0; j = 0;
        fork
            begin
                for (int t = 0; t < 20000 && i < N; t++) begin
                    e_in_tvalid = 1'($urandom_range(0, 1));
                    e_in_tdata = eq_d[i]; e_in_tkeep = eq_k[i]; e_in_tlast = eq_l[i];
                    #2;
                    if (e_in_tvalid && e_in_tready) i++;
                    @(posedge aclk); #1;
                end
                e_in_tvalid = 1'b0;
            end
            begin
                for (int t = 0; t < 20000 && j < N; t++) begin
                    e_out_tready = 1'($urandom_range(0, 1));
                    #2;
                    if (e_out_tvalid && e_out_tready) begin
                        nvec++; if ({e_out_tdata, e_out_tkeep, e_out_tlast} !== {eq_d[j], eq_k[j], eq_l[j]}) begin nerr++; $display("FAIL eq_beat %0d: got %h/%h/%b want %h/%h/%b", j, e_out_tdata, e_out_tkeep, e_out_tlast, eq_d[j], eq_k[j], eq_l[j]); end
                        j++;
                    end
                    @(posedge aclk); #1;
                end
            end
        join
        nvec++; if (j != N) begin nerr++; $display("FAIL eq_count: got %0d beats want %0d", j, N); end
        e_out_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        nvec++; if (e_out_tvalid !== 1'b0) begin nerr++; $display("FAIL eq_extra: got %b want 0", e_out_tvalid); end
    endtask

    initial begin
        a_in_tdata = '0; a_in_tkeep = '0; a_in_tlast = 1'b0; a_in_tvalid = 1'b0; a_out_tready = 1'b0;
        b_in_tdata = '0; b_in_tkeep = '0; b_in_tlast = 1'b0; b_in_tvalid = 1'b0; b_out_tready = 1'b0;
        d_in_tdata = '0; d_in_tkeep = '0; d_in_tlast = 1'b0; d_in_tvalid = 1'b0; d_out_tready = 1'b0;
        e_in_tdata = '0; e_in_tkeep = '0; e_in_tlast = 1'b0; e_in_tvalid = 1'b0; e_out_tready = 1'b0;
        test_reset;
        test_upsize;
        test_upsize_partial;
        test_downsize;
        test_backpressure;
        test_reset_mid;
        test_equal;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/axis_width_converter.md
Name: axis_width_converter

Overview:
- Generic single-clock AXI-Stream width converter; one module covers upsizing, downsizing, and equal-width pass-through, selected by integer ratio of OUT_W to IN_W.
- Adds tkeep/tlast packet handling and an optional built-in output skid buffer.
- Replaces hand-cascaded fixed-ratio upsizing/downsizing/skid_buffer chains between register slices in stream datapaths.

Parameters:
- IN_W, 256: input tdata width in bits; multiple of 8.
- OUT_W, 512: output tdata width in bits; multiple of 8. max(IN_W,OUT_W) must be an integer multiple R of min(IN_W,OUT_W); otherwise elaboration fatal.
- OUT_REG, 1: 1 = registered output skid buffer, out_tready has no combinational path to in_tready; 0 = no skid buffer.

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- in_tdata  in  IN_W  input data
- in_tkeep  in  IN_W/8  input byte enables
- in_tlast  in  1  input end of packet
- in_tvalid  in  1  input valid
- in_tready  out  1  input ready
- out_tdata  out  OUT_W  output data
- out_tkeep  out  OUT_W/8  output byte enables
- out_tlast  out  1  output end of packet
- out_tvalid  out  1  output valid
- out_tready  in  1  output ready

Behaviour:
- Reset (async assert, sync release): out_tvalid=0, out_tdata=0, out_tkeep=0, out_tlast=0, in_tready=0, slice counter=0, skid buffer empty.
- in_tready rises on the first aclk edge after release.
- Reset mid-packet discards partial accumulation and pending slices.
- AXI rules:
  - Transfer occurs when valid&&ready at the clock edge.
  - Once out_tvalid=1, out_tdata/tkeep/tlast stay stable until accepted.
  - out_tvalid never depends combinationally on out_tready.
- Ordering is little-endian: the first input beat or first output slice maps to bits [min-1:0].
- Upsize mode (OUT_W=R*IN_W):
  - Accepted beats are packed into slice k = counter.
  - Output word is emitted after the R-th beat, or earlier on any in_tlast.
  - Early tlast: unfilled slices have tdata=0 and tkeep=0; out_tlast=1; counter returns to 0.
  - out_tlast equals the tlast of the final packed beat.
- Downsize mode (IN_W=R*OUT_W):
  - Each accepted input word emits slices 0..R-1 in order.
  - in_tready=0 while slices remain; it rises so the next word can be accepted on the cycle the last slice is accepted.
  - If in_tlast=1: slices above the highest slice with any nonzero tkeep are skipped. out_tlast=1 on the last emitted slice.
  - If in_tlast=1 and tkeep is all zero: only slice 0 is emitted, with tkeep=0 and tlast=1.
  - If in_tlast=0: all R slices are emitted and out_tlast=0 on each.
- Equal width (R=1): registered pass-through; all fields propagate unchanged.
- Throughput: with out_tready held 1, no bubbles.
  - Upsize: 1 input beat/cycle, including the cycle the assembled word is handed over.
  - Downsize: 1 output slice/cycle, including across input words.
- Latency, OUT_REG=0: first output valid 1 cycle after the completing input beat is accepted.
- Latency, OUT_REG=1:
  - Same first-output latency while the skid buffer is empty.
  - The skid buffer holds one extra word when out_tready drops.
  - in_tready is a registered signal.
- Backpressure: with out_tready=0 indefinitely, nothing is lost or duplicated.
  - Upsize absorbs at most R beats + skid entry, then holds in_tready=0.
  - Downsize holds the current word.
- Simultaneous events: in the same cycle, output acceptance of word N and input acceptance of the first beat/word of N+1 are both legal and must both take effect.

Test Plan:
- Upsize 256→512: in_tdata A0,A1,B0,B1 (tkeep all 1s, tlast on A1 and B1), out_tready=1.
  - → Two outputs {A1,A0} and {B1,B0}, tlast=1 each.
  - → in_tready constantly 1; 4 inputs accepted in 4 consecutive cycles.
- Upsize 64→256, packet of 3 beats C0,C1,C2 with tlast on C2.
  - → One output: data {64'h0,C2,C1,C0}; tkeep=32'h00FF_FFFF; tlast=1.
- Downsize 512→256: word {D1,D0} tlast=0, then {E1,E0} with tkeep=64'h0000_0000_FFFF_FFFF and tlast=1.
  - → Outputs D0,D1,E0 only; tlast=1 only on E0.
  - → No bubble between D1 and E0.
- Backpressure, upsize 256→512, OUT_REG=1: stream 8 beats of an incrementing counter; out_tready toggles 1,0,0,1 repeatedly.
  - → Output words are exactly {1,0},{3,2},{5,4},{7,6}.
  - → Data stable while stalled; no drop or duplication.
- Reset mid-operation: assert areset after 1 of 2 upsize beats, then release and send F0,F1.
  - → out_tvalid=0 immediately on assertion; first output after release is {F1,F0}.
  - → in_tready=0 during reset; in_tready=1 one edge after release.
- Equal width 256→256, random tvalid/tready at 50%, 1000 beats.
  - → Output sequence identical to input (data, keep, last).
